// File: rtl/morse_pkg.sv
// morse_pkg: shared types and defaults for the morse game round controller.
//   state_e     - 3-bit FSM state encoding (START, P1, P2, RESULT, OVER)
//   DEF_*       - default parameter values for morse_round_ctrl
//   KEY_IDLE    - level of a released active-low key
package morse_pkg;

  localparam int unsigned DEF_ADDR_W  = 4;
  localparam int unsigned DEF_ROUNDS  = 3;
  localparam int unsigned DEF_SCORE_W = 4;
  localparam int unsigned STATE_W     = 3;

  localparam logic KEY_IDLE = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    ST_START  = 3'd0,
    ST_P1     = 3'd1,
    ST_P2     = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

endpackage

// File: rtl/morse_round_ctrl_key_edge.sv
// key_edge: registered press detector for an active-low level key.
// A press is a released->pressed transition between the previous sample and
// the current one; a held key yields a single one-cycle press pulse.
//   clock_1hz  in   game clock
//   resetn     in   synchronous active-low reset (key returns to idle)
//   key_n_i    in   raw active-low key level
//   press_o    out  registered one-cycle press pulse
module key_edge
  import morse_pkg::*;
(
  input  logic clock_1hz,
  input  logic resetn,
  input  logic key_n_i,
  output logic press_o
);

  logic key_q;
  logic press_q;

  // Previous key level and press pulse
  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      key_q   <= KEY_IDLE;
      press_q <= 1'b0;
    end else begin
      key_q   <= key_n_i;
      press_q <= key_q & ~key_n_i;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/morse_round_ctrl.sv
// morse_round_ctrl: multi-round controller for the two-player morse game.
// Owns the message RAM address/strobes and the player turn enables, counts
// P2 mismatches per round and keeps a running score over ROUNDS rounds.
//
// Optional build macro: MORSE_AUTO_ADVANCE_EN - when defined, P2 moves to
// RESULT on its own the cycle after it has read the whole message.
//
//   clock_1hz    in   game clock
//   resetn       in   synchronous active-low reset
//   done_n       in   done key, active-low level
//   next_n       in   next key, active-low level
//   p2_correct   in   current P2 symbol matches the stored symbol
//   p2_complete  in   P2 finished the whole code correctly
//   state        out  current FSM state (morse_pkg::state_e encoding)
//   ram_addr     out  message RAM address
//   ram_en       out  one-cycle RAM access strobe
//   ram_wren     out  RAM write enable (P1 writes only)
//   p1_active    out  player-1 turn enable
//   p2_active    out  player-2 turn enable
//   msg_len      out  symbols written by P1 this round
//   p2_idx       out  symbols read by P2 this round
//   mismatch     out  saturating mismatch count this round
//   round        out  completed rounds
//   score        out  saturating count of rounds won
//   full         out  msg_len equals RAM depth
//   game_over    out  high in OVER
module morse_round_ctrl
  import morse_pkg::*;
#(
  parameter  int unsigned ADDR_W  = DEF_ADDR_W,
  parameter  int unsigned ROUNDS  = DEF_ROUNDS,
  parameter  int unsigned SCORE_W = DEF_SCORE_W,
  localparam int unsigned LEN_W   = ADDR_W + 1,
  localparam int unsigned RND_W   = $clog2(ROUNDS + 1)
) (
  input  logic               clock_1hz,
  input  logic               resetn,
  input  logic               done_n,
  input  logic               next_n,
  input  logic               p2_correct,
  input  logic               p2_complete,
  output logic [STATE_W-1:0] state,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_en,
  output logic               ram_wren,
  output logic               p1_active,
  output logic               p2_active,
  output logic [LEN_W-1:0]   msg_len,
  output logic [LEN_W-1:0]   p2_idx,
  output logic [SCORE_W-1:0] mismatch,
  output logic [RND_W-1:0]   round,
  output logic [SCORE_W-1:0] score,
  output logic               full,
  output logic               game_over
);

  localparam int unsigned        DEPTH    = 1 << ADDR_W;
  localparam logic [LEN_W-1:0]   DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [RND_W-1:0]   ROUNDS_L = RND_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] SAT      = {SCORE_W{1'b1}};

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     msg_len_q, msg_len_d;
  logic [LEN_W-1:0]     p2_idx_q, p2_idx_d;
  logic [SCORE_W-1:0]   mismatch_q, mismatch_d;
  logic [RND_W-1:0]     round_q, round_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic                 ram_en_q, ram_en_d;
  logic                 ram_wren_q, ram_wren_d;
  logic                 full_q, full_d;
  logic                 p1_act_q, p1_act_d;
  logic                 p2_act_q, p2_act_d;
  logic                 over_q, over_d;
  logic                 entry_q, entry_d;

  logic                 done_p;
  logic                 next_p;
  logic                 next_acc;
  logic                 auto_exit;
  logic                 round_win;
  logic [RND_W-1:0]     round_eff;

  key_edge u_done_edge (
    .clock_1hz (clock_1hz),
    .resetn    (resetn),
    .key_n_i   (done_n),
    .press_o   (done_p)
  );

  key_edge u_next_edge (
    .clock_1hz (clock_1hz),
    .resetn    (resetn),
    .key_n_i   (next_n),
    .press_o   (next_p)
  );

  // A simultaneous done press swallows the next press
  assign next_acc = next_p & ~done_p;

`ifdef MORSE_AUTO_ADVANCE_EN
  assign auto_exit = (p2_idx_q == msg_len_q);
`else
  assign auto_exit = 1'b0;
`endif

  assign round_win = (mismatch_q == '0) && p2_complete && (p2_idx_q == msg_len_q);

  // Round count as it stands after this cycle; lets a done press in the
  // RESULT entry cycle see the freshly completed round
  assign round_eff = entry_q ? RND_W'(round_q + RND_W'(1)) : round_q;

  // State register
  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:  if (done_p) state_d = ST_P1;
      ST_P1:     if (done_p && (msg_len_q != '0)) state_d = ST_P2;
      ST_P2:     if (done_p || auto_exit) state_d = ST_RESULT;
      ST_RESULT: if (done_p) state_d = (round_eff == ROUNDS_L) ? ST_OVER : ST_P1;
      ST_OVER:   if (done_p) state_d = ST_START;
      default:   state_d = ST_START;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    msg_len_d  = msg_len_q;
    p2_idx_d   = p2_idx_q;
    mismatch_d = mismatch_q;
    round_d    = round_q;
    score_d    = score_q;
    ram_addr_d = ram_addr_q;
    ram_en_d   = 1'b0;
    ram_wren_d = 1'b0;
    entry_d    = (state_d == ST_RESULT) && (state_q != ST_RESULT);

    case (state_q)
      ST_START: begin
        msg_len_d  = '0;
        p2_idx_d   = '0;
        mismatch_d = '0;
      end
      ST_P1: begin
        if (next_acc && !full_q) begin
          ram_en_d   = 1'b1;
          ram_wren_d = 1'b1;
          ram_addr_d = msg_len_q[ADDR_W-1:0];
          msg_len_d  = msg_len_q + LEN_W'(1);
        end
      end
      ST_P2: begin
        if (next_acc && (p2_idx_q < msg_len_q)) begin
          ram_en_d   = 1'b1;
          ram_addr_d = p2_idx_q[ADDR_W-1:0];
          p2_idx_d   = p2_idx_q + LEN_W'(1);
          if (!p2_correct && (mismatch_q != SAT)) begin
            mismatch_d = mismatch_q + SCORE_W'(1);
          end
        end
      end
      ST_RESULT: begin
        // Score the round once, on the cycle after entry
        if (entry_q) begin
          round_d = round_eff;
          if (round_win && (score_q != SAT)) begin
            score_d = score_q + SCORE_W'(1);
          end
        end
        if (state_d == ST_P1) begin
          msg_len_d  = '0;
          p2_idx_d   = '0;
          mismatch_d = '0;
        end
      end
      ST_OVER: begin
        if (done_p) begin
          score_d    = '0;
          round_d    = '0;
          msg_len_d  = '0;
          p2_idx_d   = '0;
          mismatch_d = '0;
        end
      end
      default: ;
    endcase

    full_d   = (msg_len_d == DEPTH_L);
    p1_act_d = (state_d == ST_P1);
    p2_act_d = (state_d == ST_P2);
    over_d   = (state_d == ST_OVER);
  end

  // Datapath and output registers
  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      msg_len_q  <= '0;
      p2_idx_q   <= '0;
      mismatch_q <= '0;
      round_q    <= '0;
      score_q    <= '0;
      ram_addr_q <= '0;
      ram_en_q   <= 1'b0;
      ram_wren_q <= 1'b0;
      full_q     <= 1'b0;
      p1_act_q   <= 1'b0;
      p2_act_q   <= 1'b0;
      over_q     <= 1'b0;
      entry_q    <= 1'b0;
    end else begin
      msg_len_q  <= msg_len_d;
      p2_idx_q   <= p2_idx_d;
      mismatch_q <= mismatch_d;
      round_q    <= round_d;
      score_q    <= score_d;
      ram_addr_q <= ram_addr_d;
      ram_en_q   <= ram_en_d;
      ram_wren_q <= ram_wren_d;
      full_q     <= full_d;
      p1_act_q   <= p1_act_d;
      p2_act_q   <= p2_act_d;
      over_q     <= over_d;
      entry_q    <= entry_d;
    end
  end

  assign state     = state_q;
  assign msg_len   = msg_len_q;
  assign p2_idx    = p2_idx_q;
  assign mismatch  = mismatch_q;
  assign round     = round_q;
  assign score     = score_q;
  assign ram_addr  = ram_addr_q;
  assign ram_en    = ram_en_q;
  assign ram_wren  = ram_wren_q;
  assign full      = full_q;
  assign p1_active = p1_act_q;
  assign p2_active = p2_act_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Testbench for morse_round_ctrl: game-level reference model with a RAM
// access scoreboard checked by an independent monitor.
module tb_morse_round_ctrl;
  import morse_pkg::*;

  localparam int unsigned AW    = 2;
  localparam int unsigned NR    = 2;
  localparam int unsigned SW    = 2;
  localparam int          DEPTH = 4;
  localparam int          SMAX  = 3;

`ifdef MORSE_AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clock_1hz = 1'b0;
  logic          resetn = 1'b0;
  logic          done_n = 1'b1;
  logic          next_n = 1'b1;
  logic          p2_correct = 1'b1;
  logic          p2_complete = 1'b0;
  logic [2:0]    state;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_wren;
  logic          p1_active;
  logic          p2_active;
  logic [AW:0]   msg_len;
  logic [AW:0]   p2_idx;
  logic [SW-1:0] mismatch;
  logic [1:0]    round;
  logic [SW-1:0] score;
  logic          full;
  logic          game_over;

  morse_round_ctrl #(.ADDR_W(AW), .ROUNDS(NR), .SCORE_W(SW)) dut (
    .clock_1hz   (clock_1hz),
    .resetn      (resetn),
    .done_n      (done_n),
    .next_n      (next_n),
    .p2_correct  (p2_correct),
    .p2_complete (p2_complete),
    .state       (state),
    .ram_addr    (ram_addr),
    .ram_en      (ram_en),
    .ram_wren    (ram_wren),
    .p1_active   (p1_active),
    .p2_active   (p2_active),
    .msg_len     (msg_len),
    .p2_idx      (p2_idx),
    .mismatch    (mismatch),
    .round       (round),
    .score       (score),
    .full        (full),
    .game_over   (game_over)
  );

  always #5 clock_1hz = ~clock_1hz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int wren;
  } ram_t;

  ram_t exp_q[$];

  // Reference game state
  state_e m_state;
  int m_len, m_idx, m_mis, m_round, m_score;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(int a, int w);
    ram_t e;
    e.addr = a;
    e.wren = w;
    exp_q.push_back(e);
  endfunction

  // Monitor: every RAM strobe must match the oldest expected access
  always @(negedge clock_1hz) begin : mon
    ram_t e;
    if (ram_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ram_unexpected: got access addr %0d wren %0d expected none", ram_addr, ram_wren);
      end else begin
        e = exp_q.pop_front();
        chk("ram_addr", int'(ram_addr), e.addr);
        chk("ram_wren", int'(ram_wren), e.wren);
      end
    end
  end

  function automatic void model_reset();
    m_state = ST_START;
    m_len = 0; m_idx = 0; m_mis = 0; m_round = 0; m_score = 0;
  endfunction

  function automatic void enter_result(bit comp);
    if (m_mis == 0 && comp && m_idx == m_len && m_score < SMAX) m_score++;
    m_round++;
    m_state = ST_RESULT;
  endfunction

  // Effect of one key action, following the game rules
  function automatic void model_apply(bit d, bit nx, bit corr, bit comp);
    bit n;
    n = nx && !d;
    case (m_state)
      ST_START: if (d) m_state = ST_P1;
      ST_P1: begin
        if (n && m_len < DEPTH) begin
          push_exp(m_len, 1);
          m_len++;
        end
        if (d && m_len != 0) m_state = ST_P2;
      end
      ST_P2: begin
        if (n && m_idx < m_len) begin
          push_exp(m_idx, 0);
          m_idx++;
          if (!corr && m_mis < SMAX) m_mis++;
        end
        if (d || (AUTO && m_idx == m_len)) enter_result(comp);
      end
      ST_RESULT: if (d) begin
        if (m_round == NR) m_state = ST_OVER;
        else begin
          m_state = ST_P1;
          m_len = 0; m_idx = 0; m_mis = 0;
        end
      end
      ST_OVER: if (d) begin
        m_state = ST_START;
        m_score = 0; m_round = 0;
        m_len = 0; m_idx = 0; m_mis = 0;
      end
      default: ;
    endcase
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clock_1hz);
    #1;
  endtask

  task automatic check_all();
    chk("state",     int'(state),     int'(m_state));
    chk("msg_len",   int'(msg_len),   m_len);
    chk("p2_idx",    int'(p2_idx),    m_idx);
    chk("mismatch",  int'(mismatch),  m_mis);
    chk("round",     int'(round),     m_round);
    chk("score",     int'(score),     m_score);
    chk("full",      int'(full),      int'(m_len == DEPTH));
    chk("game_over", int'(game_over), int'(m_state == ST_OVER));
    chk("p1_active", int'(p1_active), int'(m_state == ST_P1));
    chk("p2_active", int'(p2_active), int'(m_state == ST_P2));
    chk("ram_en_idle", int'(ram_en), 0);
    chk("ram_wren_idle", int'(ram_wren), 0);
  endtask

  // One key action: predict, drive, let it settle, compare
  task automatic act(bit d, bit nx, bit corr, bit comp, int hold);
    model_apply(d, nx, corr, comp);
    done_n = !d;
    next_n = !nx;
    p2_correct = corr;
    p2_complete = comp;
    step(hold);
    done_n = 1'b1;
    next_n = 1'b1;
    step(4);
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1);
    model_reset();
    check_all();
    step(1);
    resetn = 1'b1;
    step(1);
    check_all();
  endtask

  task automatic perfect_round();
    int k;
    k = int'($urandom_range(1, DEPTH));
    for (int i = 0; i < k; i++) act(1'b0, 1'b1, 1'b1, 1'b1, 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 2);
    for (int i = 0; i < k; i++) act(1'b0, 1'b1, 1'b1, 1'b1, 1);
    if (m_state == ST_P2) act(1'b1, 1'b0, 1'b1, 1'b1, 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);
  endtask

  initial begin : stim
    bit corr_seq [3];
    int r;
    corr_seq[0] = 1'b1; corr_seq[1] = 1'b0; corr_seq[2] = 1'b1;
    model_reset();
    step(3);
    check_all();
    resetn = 1'b1;
    step(1);
    check_all();

    // Held done key: one START->P1 transition, two-cycle latency
    done_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("latency_state", int'(state), (i == 0) ? int'(ST_START) : int'(ST_P1));
    end
    done_n = 1'b1;
    model_apply(1'b1, 1'b0, 1'b1, 1'b0);
    step(4);
    check_all();

    // Empty-message done is ignored; fill past depth; done+next together
    act(1'b1, 1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 6; i++) act(1'b0, 1'b1, 1'b1, 1'b0, int'($urandom_range(1, 3)));
    act(1'b1, 1'b1, 1'b1, 1'b0, 1);

    // P2 reads with one wrong symbol, then score the round
    for (int i = 0; i < 3; i++) act(1'b0, 1'b1, corr_seq[i], 1'b0, 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);

    // Second round, three symbols, all correct
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) act(1'b0, 1'b1, 1'b1, 1'b1, 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) act(1'b0, 1'b1, 1'b1, 1'b1, 2);
    if (m_state == ST_P2) act(1'b1, 1'b0, 1'b1, 1'b1, 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);

    // Two perfect rounds, then back to START
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);
    perfect_round();
    perfect_round();
    chk("perfect_score", int'(score), 2);
    chk("perfect_over", int'(game_over), 1);
    act(1'b1, 1'b0, 1'b1, 1'b1, 1);

    // Reset in the middle of P2
    act(1'b1, 1'b0, 1'b1, 1'b0, 1);
    act(1'b0, 1'b1, 1'b1, 1'b0, 1);
    act(1'b0, 1'b1, 1'b1, 1'b0, 1);
    act(1'b1, 1'b0, 1'b1, 1'b0, 1);
    act(1'b0, 1'b1, 1'b0, 1'b0, 1);
    do_reset();

    // Random play
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) do_reset();
      else if (r < 48) act(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else if (r < 83) act(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else if (r < 93) act(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else act(1'b0, 1'b0, 1'b1, 1'b0, 1);
    end

    step(2);
    chk("ram_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
